// File: rtl/preif_pc_gen.sv
// preif_pc_gen: pre-IF program-counter generator.
//   Holds the architectural fetch PC and selects the next PC.
//   Priority: exception/ERET redirect, EXE branch redirect, replay of a
//   branch captured during a stall, then sequential +4.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   PREIF_Wr            advance enable (same enable as the IF-register write)
//   EXE_BranchTaken     branch/jump resolved taken; target on EXE_BranchTarget
//   MEM_ExcRedirect     exception entry / ERET; target on MEM_ExcTarget
//   PREIF_PC            registered fetch PC
//   PREIF_AdEL          fetch address error (PC[1:0] != 0)
//   PREIF_RedirPending  a stalled branch redirect is waiting to be applied
module preif_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PREIF_Wr,
  input  logic        EXE_BranchTaken,
  input  logic [31:0] EXE_BranchTarget,
  input  logic        MEM_ExcRedirect,
  input  logic [31:0] MEM_ExcTarget,
  output logic [31:0] PREIF_PC,
  output logic        PREIF_AdEL,
  output logic        PREIF_RedirPending
);

  typedef enum logic {
    IDLE,
    PEND_BR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;

    if (MEM_ExcRedirect) begin
      // Exception wins over everything, even while stalled; a pending
      // branch is dropped by returning to IDLE.
      pc_d    = MEM_ExcTarget;
      state_d = IDLE;
    end else if (EXE_BranchTaken && PREIF_Wr) begin
      pc_d    = EXE_BranchTarget;
      state_d = IDLE;
    end else if (EXE_BranchTaken) begin
      // Front end stalled: capture the target and replay it on the next advance.
      pend_target_d = EXE_BranchTarget;
      state_d       = PEND_BR;
    end else if ((state_q == PEND_BR) && PREIF_Wr) begin
      pc_d    = pend_target_q;
      state_d = IDLE;
    end else if (PREIF_Wr) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign PREIF_PC           = pc_q;
  assign PREIF_AdEL         = pc_q[1] | pc_q[0];
  assign PREIF_RedirPending = (state_q == PEND_BR);

endmodule

// File: tb/tb_preif_pc_gen.sv
// Testbench for preif_pc_gen: directed sequences plus random traffic.
// A reference model produces the expected PC / pending / AdEL after each
// edge and pushes it into a queue; a monitor pops and compares after
// every rising edge.
module tb_preif_pc_gen;

  logic        clk;
  logic        rst;
  logic        PREIF_Wr;
  logic        EXE_BranchTaken;
  logic [31:0] EXE_BranchTarget;
  logic        MEM_ExcRedirect;
  logic [31:0] MEM_ExcTarget;
  logic [31:0] PREIF_PC;
  logic        PREIF_AdEL;
  logic        PREIF_RedirPending;

  preif_pc_gen #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .PREIF_Wr           (PREIF_Wr),
    .EXE_BranchTaken    (EXE_BranchTaken),
    .EXE_BranchTarget   (EXE_BranchTarget),
    .MEM_ExcRedirect    (MEM_ExcRedirect),
    .MEM_ExcTarget      (MEM_ExcTarget),
    .PREIF_PC           (PREIF_PC),
    .PREIF_AdEL         (PREIF_AdEL),
    .PREIF_RedirPending (PREIF_RedirPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: architectural PC, "is a branch waiting" flag, its target.
  logic [31:0] m_pc   = 32'hBFC0_0000;
  logic        m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;

  // Drive one cycle of inputs (away from the edge) and record what the
  // outputs must be after the following rising edge.
  task automatic step(input logic r, input logic wr, input logic br,
                      input logic [31:0] bt, input logic exc,
                      input logic [31:0] et);
    exp_t e;
    @(negedge clk);
    rst              = r;
    PREIF_Wr         = wr;
    EXE_BranchTaken  = br;
    EXE_BranchTarget = bt;
    MEM_ExcRedirect  = exc;
    MEM_ExcTarget    = et;
    if (r) begin
      m_pc = 32'hBFC0_0000; m_pend = 1'b0;
    end else if (exc) begin
      m_pc = et; m_pend = 1'b0;
    end else if (br && wr) begin
      m_pc = bt; m_pend = 1'b0;
    end else if (br) begin
      m_tgt = bt; m_pend = 1'b1;
    end else if (m_pend && wr) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else if (wr) begin
      m_pc = m_pc + 32'd4;
    end
    e.pc   = m_pc;
    e.pend = m_pend;
    e.adel = (m_pc % 4) != 0;
    q.push_back(e);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0, 0, '0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  // Monitor: compare each expectation after the edge it belongs to.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (PREIF_PC !== e.pc || PREIF_RedirPending !== e.pend || PREIF_AdEL !== e.adel) begin
        miscompares++;
        $display("FAIL vec%0d: PC=%08h pend=%b adel=%b, expected PC=%08h pend=%b adel=%b",
                 vectors, PREIF_PC, PREIF_RedirPending, PREIF_AdEL, e.pc, e.pend, e.adel);
      end
    end
  end

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       rand_target = 32'hFFFF_FFFC;
      1:       rand_target = $urandom();
      default: rand_target = {$urandom()} & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    rst = 1'b1; PREIF_Wr = 1'b0; EXE_BranchTaken = 1'b0; EXE_BranchTarget = '0;
    MEM_ExcRedirect = 1'b0; MEM_ExcTarget = '0;

    // Reset, then increment: BFC00000 -> ...0C, one more to ...10.
    step(1, 0, 0, '0, 0, '0);
    step(1, 1, 0, '0, 0, '0);
    adv(4);
    // Stall at BFC00010.
    stall(4);
    // Advance to BFC00020, then a branch during a stall, replayed later.
    adv(4);
    step(0, 0, 1, 32'h8000_1000, 0, '0);
    stall(2);
    adv(2);
    // Exception and branch on the same edge, stalled.
    step(0, 0, 1, 32'h8000_2000, 1, 32'hBFC0_0380);
    adv(1);
    // Exception while a branch is pending: pending one is discarded.
    step(0, 0, 1, 32'h8000_2000, 0, '0);
    step(0, 0, 0, '0, 1, 32'hBFC0_0380);
    adv(2);
    // Newer stalled branch overwrites older pending one.
    step(0, 0, 1, 32'h8000_4000, 0, '0);
    step(0, 0, 1, 32'h8000_5000, 0, '0);
    adv(2);
    // Branch with advance overrides a pending branch.
    step(0, 0, 1, 32'h8000_6000, 0, '0);
    step(0, 1, 1, 32'h8000_7000, 0, '0);
    adv(1);
    // Wrap-around and misalignment.
    step(0, 1, 1, 32'hFFFF_FFFC, 0, '0);
    adv(2);
    step(0, 0, 0, '0, 1, 32'h8000_0002);
    adv(2);
    // Reset mid-pending: no later replay.
    step(0, 0, 1, 32'h8000_3000, 0, '0);
    step(1, 0, 0, '0, 0, '0);
    adv(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), rand_target(),
           ($urandom_range(0, 11) == 0), rand_target());
    end

    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
